// File: rtl/conv_stream_pkg.sv
// Shared constants and helpers for the convolution streaming front end.
package conv_stream_pkg;

  localparam int unsigned PixWDefault  = 8;
  localparam int unsigned LanesDefault = 8;
  localparam int unsigned KDefault     = 3;
  localparam int unsigned MaxLanes     = 64;

  // Bit offset of tap `tap` (0 = oldest) of lane `lane` in the flattened window bus.
  function automatic int unsigned win_bit_offset(input int unsigned lane, input int unsigned tap,
                                                 input int unsigned pix_w, input int unsigned k);
    return (lane * k + tap) * pix_w;
  endfunction

  // Row-start mask without padding: the first k-1 lanes lack real history.
  function automatic logic [MaxLanes-1:0] lead_lane_mask(input int unsigned lanes,
                                                          input int unsigned k);
    logic [MaxLanes-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      if ((i >= k - 1) && (i < lanes)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [MaxLanes-1:0] DefaultStartMask = lead_lane_mask(LanesDefault, KDefault);

endpackage

// File: rtl/row_beat_counter.sv
// Beat-within-row counter producing start/end-of-row flags for the current beat.
module row_beat_counter
  import conv_stream_pkg::*;
#(
  parameter int unsigned ROW_BEATS_W = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   clear_i,
  input  logic                   adv_i,
  input  logic [ROW_BEATS_W-1:0] row_beats_i,
  output logic                   sol_o,
  output logic                   eol_o
);

  logic [ROW_BEATS_W-1:0] count_q, count_d, last_beat;
  logic                   started_q, started_d;
  logic                   bounded;

  always_comb begin
    bounded   = (row_beats_i != '0);
    last_beat = row_beats_i - ROW_BEATS_W'(1);
    // Unbounded rows: only the first beat since reset/clear starts a row.
    sol_o     = bounded ? (count_q == '0) : !started_q;
    eol_o     = bounded && (count_q == last_beat);

    count_d   = count_q;
    started_d = started_q;
    if (clear_i) begin
      count_d   = '0;
      started_d = 1'b0;
    end else if (adv_i) begin
      started_d = 1'b1;
      if (!bounded || eol_o) count_d = '0;
      else                   count_d = count_q + ROW_BEATS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q   <= '0;
      started_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      started_q <= started_d;
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Streaming horizontal window generator: per-lane K-pixel windows with history across beats.
module line_window_gen
  import conv_stream_pkg::*;
#(
  parameter int unsigned PIX_W       = PixWDefault,
  parameter int unsigned LANES       = LanesDefault,
  parameter int unsigned K           = KDefault,
  parameter int unsigned ROW_BEATS_W = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     cfg_pad,
  input  logic [ROW_BEATS_W-1:0]   cfg_row_beats,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*K*PIX_W-1:0] out_windows,
  output logic [LANES-1:0]         out_mask,
  output logic                     out_sol,
  output logic                     out_eol
);

  localparam int unsigned CarryW = (K - 1) * PIX_W;
  localparam int unsigned WinW   = K * PIX_W;
  localparam int unsigned ExtW   = (LANES + K - 1) * PIX_W;
  localparam logic [LANES-1:0] StartMask = LANES'(lead_lane_mask(LANES, K));

  logic                     out_valid_q, out_valid_d;
  logic [LANES*K*PIX_W-1:0] out_windows_q, out_windows_d;
  logic [LANES-1:0]         out_mask_q, out_mask_d;
  logic                     out_sol_q, out_sol_d;
  logic                     out_eol_q, out_eol_d;
  logic [CarryW-1:0]        carry_q, carry_d;
  logic                     accept, row_sol, row_eol;
  logic [ExtW-1:0]          ext;

  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  row_beat_counter #(
    .ROW_BEATS_W(ROW_BEATS_W)
  ) u_row_beat_counter (
    .clk        (clk),
    .nrst       (nrst),
    .clear_i    (clear),
    .adv_i      (accept),
    .row_beats_i(cfg_row_beats),
    .sol_o      (row_sol),
    .eol_o      (row_eol)
  );

  always_comb begin
    // Oldest pixel at the LSB; row start replaces history with zero pixels.
    ext = {in_data, (row_sol ? {CarryW{1'b0}} : carry_q)};

    out_valid_d   = out_valid_q;
    out_windows_d = out_windows_q;
    out_mask_d    = out_mask_q;
    out_sol_d     = out_sol_q;
    out_eol_d     = out_eol_q;
    carry_d       = carry_q;

    if (clear) begin
      out_valid_d = 1'b0;
      carry_d     = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      for (int unsigned j = 0; j < LANES; j++) begin
        out_windows_d[win_bit_offset(j, 0, PIX_W, K) +: WinW] = ext[j*PIX_W +: WinW];
      end
      out_mask_d = (!cfg_pad && row_sol) ? StartMask : {LANES{1'b1}};
      out_sol_d  = row_sol;
      out_eol_d  = row_eol;
      carry_d    = in_data[(LANES-K+1)*PIX_W +: CarryW];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid_q   <= 1'b0;
      out_windows_q <= '0;
      out_mask_q    <= '0;
      out_sol_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      carry_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_windows_q <= out_windows_d;
      out_mask_q    <= out_mask_d;
      out_sol_q     <= out_sol_d;
      out_eol_q     <= out_eol_d;
      carry_q       <= carry_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_windows = out_windows_q;
  assign out_mask    = out_mask_q;
  assign out_sol     = out_sol_q;
  assign out_eol     = out_eol_q;

endmodule
